// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: store > load > fetch into a registered request slot, with an
// in-order owner FIFO that routes read data back. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              st_req_valid,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              st_req_ready,
    input  logic              lb_req_valid,
    input  logic [ADDR_W-1:0] lb_req_addr,
    output logic              lb_req_ready,
    output logic              lb_rsp_valid,
    output logic [DATA_W-1:0] lb_rsp_data,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              if_flush,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              if_mem_hazard,
    output logic              rsp_err
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic             slot_free, fifo_full, fifo_empty, read_ok;
    logic             st_win, lb_win, if_win, read_win, rsp_pop;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             owner_q  [MAX_OUTSTANDING];
    logic             squash_q [MAX_OUTSTANDING];

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;
    logic            force_if;
    assign force_if = (starve_cnt == SC_W'(STARVE_LIMIT));
`endif

    // Fullness uses the pre-pop count so a same-cycle response never frees a slot.
    always_comb begin
        st_win     = 1'b0;
        lb_win     = 1'b0;
        if_win     = 1'b0;
        slot_free  = reset & (~mem_req_valid | mem_req_ready);
        fifo_full  = (fifo_cnt == CNT_W'(MAX_OUTSTANDING));
        fifo_empty = (fifo_cnt == '0);
        read_ok    = slot_free & ~fifo_full;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (force_if && if_req_valid && read_ok)
            if_win = 1'b1;
        else
`endif
        if (st_req_valid && slot_free)
            st_win = 1'b1;
        else if (lb_req_valid && read_ok)
            lb_win = 1'b1;
        else if (if_req_valid && read_ok)
            if_win = 1'b1;
        read_win = lb_win | if_win;
        rsp_pop  = reset & mem_rsp_valid & ~fifo_empty;
    end

    assign st_req_ready  = st_win;
    assign lb_req_ready  = lb_win;
    assign if_req_ready  = if_win;
    assign if_mem_hazard = reset & if_req_valid & ~if_win;

    assign lb_rsp_valid = rsp_pop & ~owner_q[rd_ptr];
    assign if_rsp_valid = rsp_pop & owner_q[rd_ptr] & ~squash_q[rd_ptr];
    assign lb_rsp_data  = lb_rsp_valid ? mem_rsp_data : '0;
    assign if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else if (slot_free) begin
            mem_req_valid <= st_win | read_win;
            if (st_win) begin
                mem_req_we    <= 1'b1;
                mem_req_addr  <= st_req_addr;
                mem_req_wdata <= st_req_data;
            end else if (lb_win) begin
                mem_req_we    <= 1'b0;
                mem_req_addr  <= lb_req_addr;
                mem_req_wdata <= '0;
            end else if (if_win) begin
                mem_req_we    <= 1'b0;
                mem_req_addr  <= if_req_addr;
                mem_req_wdata <= '0;
            end
        end
    end

    // A flush marks every fetch entry, and the entry pushed this cycle inherits if_flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                owner_q[i]  <= 1'b0;
                squash_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (if_flush && owner_q[i])
                    squash_q[i] <= 1'b1;
            end
            if (read_win) begin
                owner_q[wr_ptr]  <= if_win;
                squash_q[wr_ptr] <= if_win & if_flush;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (rsp_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (read_win && !rsp_pop)
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!read_win && rsp_pop)
                fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rsp_err <= 1'b0;
        else if (mem_rsp_valid && fifo_empty)
            rsp_err <= 1'b1;
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (if_win)
            starve_cnt <= '0;
        else if (if_req_valid && slot_free && !force_if)
            starve_cnt <= starve_cnt + SC_W'(1);
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected memory requests and read
// responses into queues; a monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        st_req_valid = 1'b0, lb_req_valid = 1'b0, if_req_valid = 1'b0;
    logic [31:0] st_req_addr = '0, lb_req_addr = '0, if_req_addr = '0;
    logic [63:0] st_req_data = '0;
    logic        st_req_ready, lb_req_ready, if_req_ready;
    logic        lb_rsp_valid, if_rsp_valid;
    logic [63:0] lb_rsp_data, if_rsp_data;
    logic        if_flush = 1'b0;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        if_mem_hazard, rsp_err;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_t;
    typedef struct packed {
        logic        is_fetch;
        logic [63:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
        .st_req_ready(st_req_ready),
        .lb_req_valid(lb_req_valid), .lb_req_addr(lb_req_addr), .lb_req_ready(lb_req_ready),
        .lb_rsp_valid(lb_rsp_valid), .lb_rsp_data(lb_rsp_data),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_flush(if_flush),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .if_mem_hazard(if_mem_hazard), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic st_v, input logic [31:0] st_a, input logic [63:0] st_d,
                                 input logic lb_v, input logic [31:0] lb_a,
                                 input logic if_v, input logic [31:0] if_a, input logic flush,
                                 input logic mready, input logic rspv, input logic [63:0] rspd);
        @(negedge clock);
        st_req_valid = st_v;  st_req_addr = st_a;  st_req_data = st_d;
        lb_req_valid = lb_v;  lb_req_addr = lb_a;
        if_req_valid = if_v;  if_req_addr = if_a;  if_flush = flush;
        mem_req_ready = mready;
        mem_rsp_valid = rspv; mem_rsp_data = rspd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input logic rspv, input logic [63:0] rspd);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, rspv, rspd);
    endtask

    task automatic expectReq(input logic we, input logic [31:0] addr, input logic [63:0] wdata);
        req_q.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    task automatic expectRsp(input logic is_fetch, input logic [63:0] data);
        rsp_q.push_back('{is_fetch: is_fetch, data: data});
    endtask

    req_t mon_req;
    rsp_t mon_rsp;

    always @(negedge clock) begin
        #2;
        if (reset) begin
            if (mem_req_valid && mem_req_ready) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL mem_req: unexpected request we=%0b addr=%0h", mem_req_we, mem_req_addr);
                end else begin
                    mon_req = req_q.pop_front();
                    if (mem_req_we !== mon_req.we || mem_req_addr !== mon_req.addr ||
                        (mon_req.we && mem_req_wdata !== mon_req.wdata)) begin
                        errors++;
                        $display("[TB] FAIL mem_req: got we=%0b addr=%0h wdata=%0h expected we=%0b addr=%0h wdata=%0h",
                                 mem_req_we, mem_req_addr, mem_req_wdata, mon_req.we, mon_req.addr, mon_req.wdata);
                    end
                end
            end
            if (lb_rsp_valid || if_rsp_valid) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp: unexpected lb_rsp_valid=%0b if_rsp_valid=%0b", lb_rsp_valid, if_rsp_valid);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    if ((lb_rsp_valid && if_rsp_valid) || if_rsp_valid !== mon_rsp.is_fetch ||
                        (if_rsp_valid ? if_rsp_data : lb_rsp_data) !== mon_rsp.data) begin
                        errors++;
                        $display("[TB] FAIL rsp: got lb=%0b/%0h if=%0b/%0h expected fetch=%0b data=%0h",
                                 lb_rsp_valid, lb_rsp_data, if_rsp_valid, if_rsp_data, mon_rsp.is_fetch, mon_rsp.data);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state with every request input active.
        applyStimulus(1, 32'h10, 64'h1, 1, 32'h20, 1, 32'h30, 0, 1, 1, 64'h5);
        checkOutput("reset_mem_req_valid", mem_req_valid, 0);
        checkOutput("reset_st_ready", st_req_ready, 0);
        checkOutput("reset_lb_ready", lb_req_ready, 0);
        checkOutput("reset_if_ready", if_req_ready, 0);
        checkOutput("reset_hazard", if_mem_hazard, 0);
        checkOutput("reset_lb_rsp_valid", lb_rsp_valid, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        idle(0, 0);
        reset = 1'b1;

        // Store beats fetch; request appears registered one cycle later.
        applyStimulus(1, 32'h100, 64'hAAAA, 0, 0, 1, 32'h200, 0, 1, 0, 0);
        checkOutput("t1_st_ready", st_req_ready, 1);
        checkOutput("t1_if_ready", if_req_ready, 0);
        checkOutput("t1_hazard", if_mem_hazard, 1);
        expectReq(1, 32'h100, 64'hAAAA);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h200, 0, 1, 0, 0);
        checkOutput("t1_mem_we", mem_req_we, 1);
        checkOutput("t1_mem_addr", mem_req_addr, 32'h100);
        checkOutput("t1_if_ready_next", if_req_ready, 1);
        checkOutput("t1_hazard_next", if_mem_hazard, 0);
        expectReq(0, 32'h200, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hF00D_0000);
        expectRsp(1, 64'hF00D_0000);
        idle(0, 0);

        // Load held for three cycles of back-pressure, accepted on the fourth.
        applyStimulus(0, 0, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_lb_ready", lb_req_ready, 1);
        expectReq(0, 32'h300, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h900, 64'h9, 1, 32'h304, 1, 32'h908, 0, 0, 0, 0);
            checkOutput("t2_held_addr", mem_req_addr, 32'h300);
            checkOutput("t2_held_valid", mem_req_valid, 1);
            checkOutput("t2_held_readies", {st_req_ready, lb_req_ready, if_req_ready}, 3'b000);
        end
        applyStimulus(0, 0, 0, 1, 32'h304, 0, 0, 0, 1, 0, 0);
        checkOutput("t2_addr_at_accept", mem_req_addr, 32'h300);
        checkOutput("t2_lb_ready_accept", lb_req_ready, 1);
        expectReq(0, 32'h304, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h1111);
        expectRsp(0, 64'h1111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h2222);
        expectRsp(0, 64'h2222);

        // Fill the owner FIFO, then a store still wins and loads wait for a pop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 32'h400 + 32'(8 * i), 0, 0, 0, 1, 0, 0);
            checkOutput("t3_fill_lb_ready", lb_req_ready, 1);
            expectReq(0, 32'h400 + 32'(8 * i), 0);
        end
        applyStimulus(1, 32'h500, 64'hBBBB, 1, 32'h420, 0, 0, 0, 1, 0, 0);
        checkOutput("t3_full_st_ready", st_req_ready, 1);
        checkOutput("t3_full_lb_ready", lb_req_ready, 0);
        expectReq(1, 32'h500, 64'hBBBB);
        applyStimulus(0, 0, 0, 1, 32'h420, 0, 0, 0, 1, 0, 0);
        checkOutput("t3_full_lb_blocked", lb_req_ready, 0);
        applyStimulus(0, 0, 0, 1, 32'h420, 0, 0, 0, 1, 1, 64'h3333);
        checkOutput("t3_prepop_lb_blocked", lb_req_ready, 0);
        expectRsp(0, 64'h3333);
        applyStimulus(0, 0, 0, 1, 32'h420, 0, 0, 0, 1, 0, 0);
        checkOutput("t3_after_pop_lb_ready", lb_req_ready, 1);
        expectReq(0, 32'h420, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h4444 + 64'(i));
            expectRsp(0, 64'h4444 + 64'(i));
        end
        idle(0, 0);

        // Fetch, load, fetch in flight; flush drops both fetch responses.
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h600, 0, 1, 0, 0);
        checkOutput("t4_if_ready0", if_req_ready, 1);
        expectReq(0, 32'h600, 0);
        applyStimulus(0, 0, 0, 1, 32'h700, 0, 0, 0, 1, 0, 0);
        checkOutput("t4_lb_ready", lb_req_ready, 1);
        expectReq(0, 32'h700, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h608, 1, 1, 0, 0);
        checkOutput("t4_if_ready2", if_req_ready, 1);
        expectReq(0, 32'h608, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hD0);
        checkOutput("t4_d0_if_rsp", if_rsp_valid, 0);
        checkOutput("t4_d0_lb_rsp", lb_rsp_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hD1);
        checkOutput("t4_d1_lb_rsp", lb_rsp_valid, 1);
        expectRsp(0, 64'hD1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hD2);
        checkOutput("t4_d2_if_rsp", if_rsp_valid, 0);
        idle(0, 0);
        checkOutput("t4_rsp_err", rsp_err, 0);

        // Reset mid-flight clears the held request; a late response flags rsp_err.
        applyStimulus(0, 0, 0, 1, 32'h800, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_lb_ready", lb_req_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_held_valid", mem_req_valid, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'h804, 0, 0, 0, 0, 1, 64'hE0);
        checkOutput("t6_rst_mem_valid", mem_req_valid, 0);
        checkOutput("t6_rst_lb_ready", lb_req_ready, 0);
        checkOutput("t6_rst_lb_rsp", lb_rsp_valid, 0);
        checkOutput("t6_rst_err", rsp_err, 0);
        lb_req_valid = 1'b0;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hE1);
        checkOutput("t6_err_set", rsp_err, 1);
        checkOutput("t6_no_lb_rsp", lb_rsp_valid, 0);
        checkOutput("t6_no_if_rsp", if_rsp_valid, 0);
        idle(0, 0);
        checkOutput("t6_err_sticky", rsp_err, 1);

        // Continuous stores against a waiting fetch: the guard forces fetch on cycle 9.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'hA00 + 32'(i), 64'(i), 0, 0, 1, 32'hB00, 0, 1, 0, 0);
            if (GUARD && i == 8) begin
                checkOutput("t5_if_forced", if_req_ready, 1);
                checkOutput("t5_st_yield", st_req_ready, 0);
                expectReq(0, 32'hB00, 0);
            end else begin
                checkOutput("t5_if_lose", if_req_ready, 0);
                checkOutput("t5_st_win", st_req_ready, 1);
                expectReq(1, 32'hA00 + 32'(i), 64'(i));
            end
        end
        idle(0, 0);
        idle(0, 0);
        idle(0, 0);

        checkOutput("end_req_queue_empty", 64'(req_q.size()), 0);
        checkOutput("end_rsp_queue_empty", 64'(rsp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
